mul_div_unit: RTL and testbench

//  Iterative MULT/MULTU/DIV/DIVU engine that owns the HI/LO register pair.

---
 rtl/mul_div_unit.sv | 142 ++++++++++++++
 tb/tb_mul_div_unit.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine owning the HI/LO pair.
// One shift-add / restoring-subtract step per cycle on magnitudes, sign fix-up in a final cycle.
module mul_div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] input1,
   input  logic [WIDTH-1:0] input2,
   input  logic             mthi,
   input  logic             mtlo,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CntW = $clog2(WIDTH);

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e             state_q, state_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   mag_q, mag_d;
   logic [1:0]         op_q, op_d;
   logic               s1_q, s1_d, s2_q, s2_d, dz_q, dz_d, done_q, done_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;

   logic               s1_in, s2_in, q_neg, r_neg;
   logic [WIDTH-1:0]   a_mag, b_mag, quo, rem;
   logic [WIDTH:0]     msum, dtmp;
   logic [WIDTH+1:0]   ddiff;

   assign s1_in = ~op[0] & input1[WIDTH-1];
   assign s2_in = ~op[0] & input2[WIDTH-1];
   assign a_mag = s1_in ? -input1 : input1;
   assign b_mag = s2_in ? -input2 : input2;

   // acc_q holds {upper, multiplier} for multiply and {remainder, dividend/quotient} for divide
   assign msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mag_q} : '0);
   assign dtmp  = acc_q[2*WIDTH-1:WIDTH-1];
   assign ddiff = {1'b0, dtmp} - {2'b00, mag_q};

   assign quo   = acc_q[WIDTH-1:0];
   assign rem   = acc_q[2*WIDTH-1:WIDTH];
   assign q_neg = ~op_q[0] & (s1_q ^ s2_q);
   assign r_neg = ~op_q[0] & s1_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      mag_d   = mag_q;
      op_d    = op_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      dz_d    = dz_q;
      hi_d    = hi_q;
      lo_d    = lo_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (mthi) hi_d = input1;
            if (mtlo) lo_d = input1;
            if (start) begin
               state_d = StRun;
               cnt_d   = '0;
               op_d    = op;
               s1_d    = s1_in;
               s2_d    = s2_in;
               dz_d    = (input2 == '0);
               if (op[1]) begin
                  mag_d = b_mag;
                  acc_d = {{WIDTH{1'b0}}, a_mag};
               end else begin
                  mag_d = a_mag;
                  acc_d = {{WIDTH{1'b0}}, b_mag};
               end
            end
         end
         StRun: begin
            if (op_q[1]) begin
               if (ddiff[WIDTH+1]) acc_d = {dtmp[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
               else                acc_d = {ddiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = {msum, acc_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
         end
         StFix: begin
            state_d = StIdle;
            done_d  = 1'b1;
            if (op_q[1]) begin
               // Divide by zero falls out as remainder = dividend; only the quotient is forced
               lo_d = dz_q ? '1 : (q_neg ? -quo : quo);
               hi_d = r_neg ? -rem : rem;
            end else begin
               {hi_d, lo_d} = q_neg ? -acc_q : acc_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
         mag_q   <= '0;
         op_q    <= '0;
         s1_q    <= 1'b0;
         s2_q    <= 1'b0;
         dz_q    <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         mag_q   <= mag_d;
         op_q    <= op_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         dz_q    <= dz_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         done_q  <= done_d;
      end
   end

   assign busy = (state_q != StIdle);
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit: arithmetic corners, latency, moves,
// start-while-busy and mid-op reset.
module tb_mul_div_unit;

   logic        clk, reset, start, mthi, mtlo;
   logic [1:0]  op;
   logic [31:0] input1, input2;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks   = 0;
   int failures = 0;

   mul_div_unit #(.WIDTH(32)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .input1 (input1),
      .input2 (input2),
      .mthi   (mthi),
      .mtlo   (mtlo),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Issue one op, wait for done within a bound, then check latency, hold, result, pulse width
   task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic mv, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
      int n;
      logic held;
      logic [31:0] hi0, lo0;
      @(negedge clk);
      start = 1'b1; op = o; input1 = a; input2 = b; mthi = mv;
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0;
      check({tag, " busy"}, {63'd0, busy}, 64'd1);
      if (mv) check({tag, " mthi+start"}, {32'd0, hi}, {32'd0, a});
      hi0 = hi; lo0 = lo; held = 1'b1; n = 0;
      while (!done && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (!done && (hi !== hi0 || lo !== lo0)) held = 1'b0;
      end
      check({tag, " latency"}, 64'(n), 64'd33);
      check({tag, " hold"}, {63'd0, held}, 64'd1);
      check({tag, " busy@done"}, {63'd0, busy}, 64'd0);
      check({tag, " hi"}, {32'd0, hi}, {32'd0, exp_hi});
      check({tag, " lo"}, {32'd0, lo}, {32'd0, exp_lo});
      @(posedge clk); #1;
      check({tag, " done pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int n, pulses, done_at;
      logic [31:0] lo_keep;
      reset = 1'b1; start = 1'b0; op = 2'b00; input1 = '0; input2 = '0;
      mthi = 1'b0; mtlo = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      check("reset busy", {63'd0, busy}, 64'd0);
      check("reset done", {63'd0, done}, 64'd0);
      check("reset hilo", {hi, lo}, 64'd0);

      // Moves while idle, including both at once
      @(negedge clk); mthi = 1'b1; input1 = 32'hABCD_0000;
      @(posedge clk); #1 mthi = 1'b0;
      check("mthi", {32'd0, hi}, 64'h0000_0000_ABCD_0000);
      @(negedge clk); mtlo = 1'b1; input1 = 32'h1234_5678;
      @(posedge clk); #1 mtlo = 1'b0;
      check("mtlo", {hi, lo}, 64'hABCD_0000_1234_5678);
      @(negedge clk); mthi = 1'b1; mtlo = 1'b1; input1 = 32'h5A5A_0F0F;
      @(posedge clk); #1 begin mthi = 1'b0; mtlo = 1'b0; end
      check("mthi+mtlo", {hi, lo}, 64'h5A5A_0F0F_5A5A_0F0F);

      run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("mult -5*3", 2'b00, 32'hFFFF_FFFB, 32'd3, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
      run_op("mult minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 32'h0);
      run_op("multu mv", 2'b01, 32'd2, 32'd3, 1'b1, 32'd0, 32'd6);
      run_op("div -7/2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("div 7/-2", 2'b10, 32'd7, 32'hFFFF_FFFE, 1'b0, 32'd1, 32'hFFFF_FFFD);
      run_op("divu 5/0", 2'b11, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF);
      run_op("div -7/0", 2'b10, 32'hFFFF_FFF9, 32'd0, 1'b0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
      run_op("div ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000);
      run_op("divu big", 2'b11, 32'hFFFF_FFFF, 32'd16, 1'b0, 32'd15, 32'h0FFF_FFFF);

      // DIVU 100/7 with a second start and an mtlo landing mid-flight
      @(negedge clk);
      start = 1'b1; op = 2'b11; input1 = 32'd100; input2 = 32'd7;
      @(posedge clk); #1 start = 1'b0;
      lo_keep = lo; pulses = 0; done_at = 0;
      for (n = 1; n <= 45; n++) begin
         @(posedge clk); #1;
         if (done) begin pulses++; if (done_at == 0) done_at = n; end
         if (n == 9) begin
            start = 1'b1; mtlo = 1'b1; op = 2'b01; input1 = 32'hDEAD_BEEF; input2 = 32'd3;
         end
         if (n == 10) begin
            start = 1'b0; mtlo = 1'b0;
            check("mtlo busy", {32'd0, lo}, {32'd0, lo_keep});
         end
         if (n == done_at) check("restart result", {hi, lo}, {32'd2, 32'd14});
      end
      check("restart done cycle", 64'(done_at), 64'd33);
      check("restart pulses", 64'(pulses), 64'd1);

      // Reset during a MULT aborts it and clears HI/LO
      @(negedge clk);
      start = 1'b1; op = 2'b00; input1 = 32'd1234; input2 = 32'd5678;
      @(posedge clk); #1 start = 1'b0;
      repeat (14) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      check("abort busy", {63'd0, busy}, 64'd0);
      check("abort hilo", {hi, lo}, 64'd0);
      pulses = 0;
      for (n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if (done) pulses++;
      end
      check("abort no done", 64'(pulses), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
